fibonacci_index_decoder: RTL and testbench

//  Inverse of the fibonacci0 generator. Takes a 32-bit value and finds the index n for which

---
 rtl/fibonacci_index_decoder_pkg.sv | 17 +
 rtl/fibonacci_index_decoder_step.sv | 19 +
 rtl/fibonacci_index_decoder.sv | 97 +++++++++
 tb/tb_fibonacci_index_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fibonacci_index_decoder_pkg.sv
// Shared types and constants for the Fibonacci index decoder and step unit.
package fib_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned N_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int unsigned max_n(input int unsigned nw);
    return (32'd1 << nw) - 32'd1;
  endfunction

endpackage

// File: rtl/fibonacci_index_decoder_step.sv
// One Fibonacci step: (cur, prv) -> (cur+prv, cur), flagging carry-out of the sum.
module fib_step_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] prv,
  output logic [DATA_W-1:0] next_cur,
  output logic [DATA_W-1:0] next_prv,
  output logic              ovf
);

  logic [DATA_W:0] sum;

  assign sum      = {1'b0, cur} + {1'b0, prv};
  assign next_cur = sum[DATA_W-1:0];
  assign ovf      = sum[DATA_W];
  assign next_prv = cur;

endmodule

// File: rtl/fibonacci_index_decoder.sv
// Finds n such that the fibonacci0 generator emits data as gen(n) = F(n+2),
// walking one term per cycle and pulsing done with found/n.
module fibonacci_index_decoder
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_W    = N_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [N_W-1:0]    n
);

  localparam logic [N_W-1:0] MAX_N = N_W'(max_n(N_W));

  state_t            state;
  logic [DATA_W-1:0] tgt, cur, prv;
  logic [N_W-1:0]    idx;
  logic              cur_ovf;
  logic [DATA_W-1:0] next_cur, next_prv;
  logic              step_ovf;

  fib_step_unit #(.DATA_W(DATA_W)) u_step (
    .cur      (cur),
    .prv      (prv),
    .next_cur (next_cur),
    .next_prv (next_prv),
    .ovf      (step_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tgt     <= '0;
      cur     <= '0;
      prv     <= '0;
      idx     <= '0;
      cur_ovf <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      n       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tgt     <= data;
            cur     <= DATA_W'(1);
            prv     <= DATA_W'(1);
            idx     <= '0;
            cur_ovf <= 1'b0;
            found   <= 1'b0;
            n       <= '0;
            busy    <= 1'b1;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          // cur_ovf marks a term whose true value no longer fits, so it beats any target
          if (!cur_ovf && cur == tgt) begin
            found <= 1'b1;
            n     <= idx;
            done  <= 1'b1;
            state <= DONE;
          end else if (cur_ovf || cur > tgt || idx == MAX_N) begin
            found <= 1'b0;
            n     <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cur     <= next_cur;
            prv     <= next_prv;
            cur_ovf <= step_ovf;
            idx     <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_index_decoder.sv
// Directed vector bench for the Fibonacci index decoder: table of values plus
// hand-written sequences for ignored start, reset abort and start/reset collision.
module tb_fibonacci_index_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic        busy, done, found;
  logic [3:0]  n;

  int checks   = 0;
  int failures = 0;

  fibonacci_index_decoder #(.DATA_W(32), .N_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .found (found),
    .n     (n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
    logic [3:0]  nn;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch a search, then measure the cycle (T+lat) in which done appears.
  task automatic run(input logic [31:0] d, input logic ef, input logic [3:0] en, input int lat);
    int   cyc;
    logic seen, bad_busy;
    @(negedge clk);
    start = 1'b1; data = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; seen = 1'b0; bad_busy = 1'b0;
    while (!seen && cyc <= 40) begin
      if (!busy) bad_busy = 1'b1;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'(lat));
    chk("busy_during_search", 32'(bad_busy), 32'd0);
    chk("found", 32'(found), 32'(ef));
    chk("n", 32'(n), 32'(en));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("found_hold", 32'(found), 32'(ef));
    chk("n_hold", 32'(n), 32'(en));
  endtask

  vec_t vecs[$];

  initial begin
    int          dones, done_cyc;
    logic [31:0] a, b, t;

    a = 32'd1; b = 32'd1;
    for (int i = 0; i < 16; i++) begin
      vecs.push_back('{a, 1'b1, 4'(i), i + 2});
      t = a + b; b = a; a = t;
    end
    vecs.push_back('{32'd0,          1'b0, 4'd0, 2});
    vecs.push_back('{32'd4,          1'b0, 4'd0, 5});
    vecs.push_back('{32'd7,          1'b0, 4'd0, 6});
    vecs.push_back('{32'd100,        1'b0, 4'd0, 12});
    vecs.push_back('{32'd1000,       1'b0, 4'd0, 17});
    vecs.push_back('{32'd2584,       1'b0, 4'd0, 17});
    vecs.push_back('{32'hFFFF_FFFF,  1'b0, 4'd0, 17});
    vecs.push_back('{32'h8000_0000,  1'b0, 4'd0, 17});

    reset = 1'b1; start = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_found", 32'(found), 32'd0);
    chk("reset_n", 32'(n), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run(vecs[i].d, vecs[i].f, vecs[i].nn, vecs[i].lat);

    // Second start at T+3 with different data must not restart or re-sample.
    @(negedge clk);
    start = 1'b1; data = 32'd13;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; done_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin start = 1'b1; data = 32'd1; end
      else begin start = 1'b0; data = 32'd13; end
      if (done) begin dones++; done_cyc = c; end
      @(negedge clk);
    end
    chk("ignored_start_dones", 32'(dones), 32'd1);
    chk("ignored_start_latency", 32'(done_cyc), 32'd7);
    chk("ignored_start_found", 32'(found), 32'd1);
    chk("ignored_start_n", 32'(n), 32'd5);

    // Reset during a search aborts without a done pulse.
    start = 1'b1; data = 32'd13;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_found", 32'(found), 32'd0);
    chk("abort_n", 32'(n), 32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Start coinciding with reset: reset wins.
    start = 1'b1; reset = 1'b1; data = 32'd13;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("start_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start_reset_busy2", 32'(busy), 32'd0);

    run(32'd13, 1'b1, 4'd5, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
